// File: rtl/tt_mux_ctrl_rx.sv
// Pad-driven design selector: synchronizes ctrl_* pins, counts select pulses, latches address on enable.
// Define TT_MUX_CTRL_PROT_ERR_EN to build the sticky protocol-error flag.
module tt_mux_ctrl_rx #(
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    output logic [ADDR_W-1:0] sel_count,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              design_ena,
    output logic              prot_err
);

    typedef enum logic {
        SELECT = 1'b0,
        ENABLE = 1'b1
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] inc_sync;
    logic [SYNC_STAGES-1:0] ena_sync;
    logic                   inc_hist;
    logic                   ena_hist;
    logic [SYNC_STAGES:0]   warm;

    logic [ADDR_W-1:0] count_d;
    logic [ADDR_W-1:0] addr_d;

    logic rst_s;
    logic inc_s;
    logic ena_s;
    logic inc_rise;
    logic ena_rise;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_sync <= '0;
            inc_sync <= '0;
            ena_sync <= '0;
            inc_hist <= 1'b0;
            ena_hist <= 1'b0;
            warm     <= '0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst_n};
            inc_sync <= {inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
            ena_sync <= {ena_sync[SYNC_STAGES-2:0], ctrl_ena};
            inc_hist <= inc_sync[SYNC_STAGES-1];
            ena_hist <= ena_sync[SYNC_STAGES-1];
            warm     <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rst_s = rst_sync[SYNC_STAGES-1];
    assign inc_s = inc_sync[SYNC_STAGES-1];
    assign ena_s = ena_sync[SYNC_STAGES-1];

    // Edges are ignored until the history flops hold real pad levels,
    // so a pin already high at reset release is not seen as a new edge.
    assign inc_rise = warm[SYNC_STAGES] & inc_s & ~inc_hist;
    assign ena_rise = warm[SYNC_STAGES] & ena_s & ~ena_hist;

    always_comb begin
        state_d = state;
        count_d = sel_count;
        addr_d  = sel_addr;
        unique case (state)
            SELECT: begin
                if (!rst_s) begin
                    count_d = '0;
                end else if (ena_rise) begin
                    state_d = ENABLE;
                    addr_d  = sel_count;
                end else if (inc_rise) begin
                    count_d = sel_count + ADDR_W'(1);
                end
            end
            ENABLE: begin
                if (!rst_s) begin
                    state_d = SELECT;
                    count_d = '0;
                end else if (!ena_s) begin
                    state_d = SELECT;
                end
            end
            default: state_d = SELECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= SELECT;
            sel_count <= '0;
            sel_addr  <= '0;
        end else begin
            state     <= state_d;
            sel_count <= count_d;
            sel_addr  <= addr_d;
        end
    end

    assign design_ena = (state == ENABLE);

`ifdef TT_MUX_CTRL_PROT_ERR_EN
    logic err_q;
    logic err_evt;
    logic err_clr;

    // A select pulse is illegal once enable has been (or is being) taken.
    assign err_evt = inc_rise & ((state == ENABLE) | (rst_s & ena_rise));
    assign err_clr = (state == SELECT) & ~rst_s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign prot_err = err_q;
`else
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_mux_ctrl_rx.sv
// Directed bench for tt_mux_ctrl_rx: select/enable flow, wrap, latency, reset.
// Honours TT_MUX_CTRL_PROT_ERR_EN for the expected error flag.
module tb_tt_mux_ctrl_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sel_rst_n;
    logic       inc;
    logic       ena;
    logic [9:0] cnt;
    logic [9:0] addr;
    logic       dena;
    logic       perr;
    logic [3:0] cnt4;
    logic [3:0] addr4;
    logic       dena4;
    logic       perr4;

    int total = 0;
    int bad   = 0;

`ifdef TT_MUX_CTRL_PROT_ERR_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    always #5 clk = ~clk;

    tt_mux_ctrl_rx dut (
        .clk(clk), .reset_n(reset_n),
        .ctrl_sel_rst_n(sel_rst_n), .ctrl_sel_inc(inc), .ctrl_ena(ena),
        .sel_count(cnt), .sel_addr(addr),
        .design_ena(dena), .prot_err(perr)
    );

    tt_mux_ctrl_rx #(.ADDR_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .ctrl_sel_rst_n(sel_rst_n), .ctrl_sel_inc(inc), .ctrl_ena(ena),
        .sel_count(cnt4), .sel_addr(addr4),
        .design_ena(dena4), .prot_err(perr4)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            inc = 1'b1; cyc(3);
            inc = 1'b0; cyc(3);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; sel_rst_n = 1'b1; inc = 1'b0; ena = 1'b0;
        cyc(3);
        total++; if (cnt !== 10'd0) begin bad++; $display("FAIL rst_cnt got %0d want 0", cnt); end
        total++; if (addr !== 10'd0) begin bad++; $display("FAIL rst_addr got %0d want 0", addr); end
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL rst_ena got %b want 0", dena); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", perr); end
        reset_n = 1'b1;
        cyc(6);
    endtask

    task automatic test_wrap;
        sel_rst_n = 1'b0; cyc(3);
        sel_rst_n = 1'b1; cyc(4);
        for (int i = 0; i < 17; i++) begin
            pulses(1);
            if (i == 14) begin
                total++; if (cnt4 !== 4'd15) begin bad++; $display("FAIL wrap_15 got %0d want 15", cnt4); end
            end
        end
        total++; if (cnt4 !== 4'd1) begin bad++; $display("FAIL wrap_4b got %0d want 1", cnt4); end
        total++; if (cnt !== 10'd17) begin bad++; $display("FAIL wrap_10b got %0d want 17", cnt); end
    endtask

    task automatic test_select_enable;
        sel_rst_n = 1'b0; cyc(3);
        sel_rst_n = 1'b1; cyc(4);
        total++; if (cnt !== 10'd0) begin bad++; $display("FAIL sel_clr got %0d want 0", cnt); end
        pulses(5);
        total++; if (cnt !== 10'd5) begin bad++; $display("FAIL sel_cnt5 got %0d want 5", cnt); end
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL sel_ena0 got %b want 0", dena); end
        ena = 1'b1;
        @(negedge clk);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL lat_e1 got %b want 0", dena); end
        @(negedge clk);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL lat_e2 got %b want 0", dena); end
        @(negedge clk);
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL lat_e3 got %b want 1", dena); end
        total++; if (addr !== 10'd5) begin bad++; $display("FAIL en_addr got %0d want 5", addr); end
        total++; if (cnt !== 10'd5) begin bad++; $display("FAIL en_cnt got %0d want 5", cnt); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL en_err got %b want 0", perr); end
    endtask

    task automatic test_enable_inc;
        pulses(2);
        total++; if (cnt !== 10'd5) begin bad++; $display("FAIL eninc_cnt got %0d want 5", cnt); end
        total++; if (addr !== 10'd5) begin bad++; $display("FAIL eninc_addr got %0d want 5", addr); end
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL eninc_ena got %b want 1", dena); end
        total++; if (perr !== PE) begin bad++; $display("FAIL eninc_err got %b want %b", perr, PE); end
    endtask

    task automatic test_enable_clear;
        sel_rst_n = 1'b0; cyc(4);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL enclr_ena got %b want 0", dena); end
        total++; if (cnt !== 10'd0) begin bad++; $display("FAIL enclr_cnt got %0d want 0", cnt); end
        total++; if (addr !== 10'd5) begin bad++; $display("FAIL enclr_addr got %0d want 5", addr); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL enclr_err got %b want 0", perr); end
        sel_rst_n = 1'b1; ena = 1'b0; cyc(4);
        pulses(5);
        ena = 1'b1; cyc(4);
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL reen_ena got %b want 1", dena); end
        total++; if (addr !== 10'd5) begin bad++; $display("FAIL reen_addr got %0d want 5", addr); end
        total++; if (cnt !== 10'd5) begin bad++; $display("FAIL reen_cnt got %0d want 5", cnt); end
        ena = 1'b0; cyc(4);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL dis_ena got %b want 0", dena); end
        total++; if (addr !== 10'd5) begin bad++; $display("FAIL dis_addr got %0d want 5", addr); end
    endtask

    task automatic test_clear_vs_inc;
        sel_rst_n = 1'b0; inc = 1'b1; cyc(3);
        sel_rst_n = 1'b1; cyc(2);
        inc = 1'b0; cyc(4);
        total++; if (cnt !== 10'd0) begin bad++; $display("FAIL clrwin_cnt got %0d want 0", cnt); end
        ena = 1'b1; cyc(4);
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL clrwin_ena got %b want 1", dena); end
        total++; if (addr !== 10'd0) begin bad++; $display("FAIL clrwin_addr got %0d want 0", addr); end
        reset_n = 1'b0; cyc(2);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL hold_rst got %b want 0", dena); end
        reset_n = 1'b1; cyc(8);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL hold_rel got %b want 0", dena); end
        ena = 1'b0; cyc(4);
        ena = 1'b1; cyc(4);
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL fresh_ena got %b want 1", dena); end
    endtask

    task automatic test_reset_mid;
        ena = 1'b0; cyc(4);
        pulses(9);
        ena = 1'b1; cyc(4);
        total++; if (cnt !== 10'd9) begin bad++; $display("FAIL mid_cnt got %0d want 9", cnt); end
        total++; if (addr !== 10'd9) begin bad++; $display("FAIL mid_addr got %0d want 9", addr); end
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL mid_ena got %b want 1", dena); end
        reset_n = 1'b0;
        #1;
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL sync_rst_ena got %b want 1", dena); end
        total++; if (cnt !== 10'd9) begin bad++; $display("FAIL sync_rst_cnt got %0d want 9", cnt); end
        @(negedge clk);
        total++; if (cnt !== 10'd0) begin bad++; $display("FAIL midr_cnt got %0d want 0", cnt); end
        total++; if (addr !== 10'd0) begin bad++; $display("FAIL midr_addr got %0d want 0", addr); end
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL midr_ena got %b want 0", dena); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL midr_err got %b want 0", perr); end
        reset_n = 1'b1; cyc(6);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL midr_hold got %b want 0", dena); end
    endtask

    task automatic test_ena_inc_same;
        ena = 1'b0; cyc(4);
        pulses(3);
        total++; if (cnt !== 10'd3) begin bad++; $display("FAIL same_pre got %0d want 3", cnt); end
        inc = 1'b1; ena = 1'b1; cyc(4);
        inc = 1'b0; cyc(3);
        total++; if (addr !== 10'd3) begin bad++; $display("FAIL same_addr got %0d want 3", addr); end
        total++; if (cnt !== 10'd3) begin bad++; $display("FAIL same_cnt got %0d want 3", cnt); end
        total++; if (dena !== 1'b1) begin bad++; $display("FAIL same_ena got %b want 1", dena); end
        total++; if (perr !== PE) begin bad++; $display("FAIL same_err got %b want %b", perr, PE); end
        ena = 1'b0; cyc(4);
        total++; if (dena !== 1'b0) begin bad++; $display("FAIL same_exit got %b want 0", dena); end
        total++; if (perr !== PE) begin bad++; $display("FAIL same_sticky got %b want %b", perr, PE); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_select_enable();
        test_enable_inc();
        test_enable_clear();
        test_clear_vs_inc();
        test_reset_mid();
        test_ena_inc_same();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_mux_ctrl_rx.md
TT_MUX_CTRL_RX -- requirements
Module: tt_mux_ctrl_rx

Interface
REQ-001 Parameter ADDR_W, default 10, width of design-select counter and address.
REQ-002 Parameter SYNC_STAGES, default 2 (legal 2..4), flip-flop depth of each input synchronizer.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 ctrl_sel_rst_n  input  1  async pad input, active-low; clears select counter.
REQ-006 ctrl_sel_inc  input  1  async pad input; each rising edge advances select counter by one.
REQ-007 ctrl_ena  input  1  async pad input; high = enable selected design.
REQ-008 sel_count  output  ADDR_W  live select counter.
REQ-009 sel_addr  output  ADDR_W  address latched at enable; stable while design_ena high.
REQ-010 design_ena  output  1  selected design enabled.
REQ-011 prot_err  output  1  sticky protocol-error flag.

Function
REQ-012 Each ctrl_* input SHALL pass through its own SYNC_STAGES-deep synchronizer before any use; rising-edge detection SHALL use the synchronized value and one history register.
REQ-013 Latency: a ctrl_* transition captured at edge k SHALL affect outputs after edge k+SYNC_STAGES, no earlier, no later.
REQ-014 Inputs held at each level for at least 2 clk cycles SHALL never be missed; each synchronized rising edge of ctrl_sel_inc SHALL count exactly once.
REQ-015 FSM states: SELECT, ENABLE; only these two encodings reachable.
REQ-016 SELECT: synchronized sel_rst_n low -> sel_count=0; else inc rising edge -> sel_count+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-017 SELECT: sel_rst_n low and inc edge on same cycle -> sel_count=0 (clear wins).
REQ-018 SELECT -> ENABLE on synchronized ctrl_ena rising edge with sel_rst_n high; same edge loads sel_addr=sel_count, design_ena=1.
REQ-019 ctrl_ena rising while sel_rst_n low -> stay in SELECT, design_ena stays 0, sel_count=0.
REQ-020 ctrl_ena rising in the same cycle as an inc edge -> sel_addr takes the pre-increment value; the increment is discarded and counts as a protocol error.
REQ-021 ENABLE: inc edges SHALL not modify sel_count or sel_addr; each is a protocol error.
REQ-022 ENABLE -> SELECT when synchronized ctrl_ena low or sel_rst_n low; design_ena=0 on that edge; sel_addr retains last value.
REQ-023 ENABLE exit by sel_rst_n low SHALL also clear sel_count to 0 on the same edge.
REQ-024 ctrl_ena held high at reset release SHALL not enable; a fresh synchronized rising edge is required.

Reset
REQ-025 reset_n low at a rising clk edge: state=SELECT, sel_count=0, sel_addr=0, design_ena=0, prot_err=0, synchronizer and history flops=0.
REQ-026 Reset mid-operation (either state) SHALL take effect on that edge, overriding all other events; no partial increment.
REQ-027 Reset SHALL not act asynchronously; outputs unchanged until the next clk edge.

Configuration
REQ-028 Macro TT_MUX_CTRL_PROT_ERR_EN defined: prot_err set on any protocol error (REQ-020, REQ-021), held until reset_n low or synchronized sel_rst_n low in SELECT.
REQ-029 Macro undefined: prot_err constant 0, no error-flag logic synthesized; all other behaviour identical.

Verification
REQ-030 Reset, sel_rst_n pulse low, 5 inc pulses (3 clk high/3 clk low), ena high -> sel_count=5, sel_addr=5, design_ena=1 exactly SYNC_STAGES edges after ena captured.
REQ-031 ADDR_W=4: 17 inc pulses from 0 -> sel_count=1 (wrap at 15->0).
REQ-032 In ENABLE with sel_addr=5: 2 inc pulses -> sel_count/sel_addr stay 5; prot_err=1 with macro, 0 without.
REQ-033 In ENABLE: sel_rst_n low -> design_ena=0, sel_count=0, sel_addr=5; ena reasserted after 5 incs -> sel_addr=5 again.
REQ-034 sel_rst_n low and inc rising same cycle, then ena -> sel_count=0, sel_addr=0; ena high through reset release -> design_ena remains 0.
REQ-035 reset_n low for one edge during ENABLE with sel_count=9 -> all outputs 0 after that edge, state SELECT.
